alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one ALU, legal 2..8.
REQ-002 Parameter TIMEOUT, default 16: maximum cycles waited for alu_done before an error response is returned.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NUM_REQ  per-requester request pending.
REQ-006 req_data  input  NUM_REQ*10  per-requester slice {op[9:8], b[7:4], a[3:0]}; requester i occupies bits [10i+9:10i].
REQ-007 req_ready  output  NUM_REQ  one-hot accept strobe, one cycle.
REQ-008 alu_start  output  1  one-cycle start pulse to the ALU.
REQ-009 alu_op  output  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
REQ-010 alu_a, alu_b  output  4 each  operands.
REQ-011 alu_done  input  1  ALU result valid pulse.
REQ-012 alu_result  input  9  ALU result, sampled only when alu_done=1.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_id  output  3  index of the requester that owns the response.
REQ-015 rsp_result  output  9  result value.
REQ-016 rsp_err  output  1  response is an error (divide-by-zero or timeout).
REQ-017 rsp_ready  input  1  consumer accepts the response.

Function
REQ-018 FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESPOND.
REQ-019 IDLE, any req_valid=1: grant one requester round-robin, starting search at last_grant+1 mod NUM_REQ.
  - Pulse req_ready[grant] in the same cycle.
  - Latch op/a/b and the grant id.
  - Go to ISSUE.
REQ-020 IDLE, no req_valid: remain in IDLE; req_ready SHALL be all zero.
REQ-021 ISSUE, latched op=DIV and b=0:
  - Do not pulse alu_start.
  - Set rsp_result=9'h1FF, rsp_err=1.
  - Go to RESPOND.
REQ-022 ISSUE, all other operations: pulse alu_start with latched alu_op/a/b for one cycle, then go to WAIT.
REQ-023 alu_op/a/b SHALL hold their latched values from ISSUE until alu_done or timeout.
REQ-024 WAIT, on alu_done=1: latch alu_result into rsp_result, set rsp_err=0, go to RESPOND.
REQ-025 WAIT, TIMEOUT cycles without alu_done: set rsp_result=9'h1FF, rsp_err=1, go to RESPOND.
REQ-026 Wait counter SHALL be saturating; it SHALL clear on entry to WAIT.
REQ-027 alu_done received outside WAIT SHALL be ignored.
REQ-028 RESPOND: hold rsp_valid=1 with rsp_id/rsp_result/rsp_err stable until rsp_ready=1.
  - On the rsp_ready=1 cycle: update last_grant to the served id, then go to IDLE.
REQ-029 No new request SHALL be accepted while not in IDLE; exactly one request is in flight.
REQ-030 A requester that drops req_valid before being granted SHALL NOT be served; it loses no other state.
REQ-031 Minimum latency: grant cycle N, alu_start N+1, alu_done N+2 earliest, rsp_valid N+3.
  - Divide-by-zero responds at N+2.
REQ-032 Round-robin SHALL be fair: with all NUM_REQ requesters continuously valid, each is served exactly once per NUM_REQ responses.

Reset
REQ-033 On reset, regardless of current state:
  - state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), wait counter=0.
  - req_ready=0, alu_start=0, alu_op/a/b=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0.
REQ-034 Reset mid-operation SHALL abort the in-flight request with no response; a late alu_done after reset SHALL be ignored.

Structure
REQ-035 Shared package alu_pkg SHALL hold:
  - op encoding (ADD/SUB/MUL/DIV)
  - FSM state enum
  - ERR_RESULT constant 9'h1FF
  - request field widths and offsets.
REQ-036 Round-robin grant logic SHALL be a separate sub-module rr_arbiter (inputs: request vector, last_grant; outputs: one-hot grant, grant index).

Verification
REQ-037 Req0 only, ADD a=5 b=3, ALU done one cycle after start -> req_ready[0] pulse; rsp_id=0, rsp_result=8, rsp_err=0, rsp_valid three cycles after grant.
REQ-038 Req1 and req2 simultaneous after reset, both MUL a=3 b=4 -> req1 served first, then req2; both rsp_result=12.
REQ-039 Req3 DIV a=9 b=0 -> no alu_start; rsp_id=3, rsp_result=9'h1FF, rsp_err=1.
REQ-040 Req0 SUB a=7 b=2, alu_done never asserted -> after 16 WAIT cycles: rsp_result=9'h1FF, rsp_err=1.
REQ-041 Response held with rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready stays 0; accepted on cycle 6, then next grant.
REQ-042 Reset asserted in WAIT, then alu_done pulses -> all outputs 0, no rsp_valid; next req0 grant behaves as after power-up.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: op encoding, FSM states,
// request-slice layout, the error result constant, and small decode helpers.
// Latency: n/a (types and constants only). Backpressure: n/a.
package alu_pkg;

  // ALU operation encoding as seen on alu_op and in req_data[9:8].
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  // Arbiter control FSM.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_e;

  // Per-requester slice layout: {op[9:8], b[7:4], a[3:0]}.
  localparam int REQ_W  = 10;
  localparam int A_OFF  = 0;
  localparam int A_W    = 4;
  localparam int B_OFF  = 4;
  localparam int B_W    = 4;
  localparam int OP_OFF = 8;
  localparam int OP_W   = 2;

  // Requester ids are 3 bits wide, enough for the largest legal NUM_REQ of 8.
  localparam int MAX_REQ = 8;
  localparam int ID_W    = 3;
  localparam int RES_W   = 9;

  localparam logic [RES_W-1:0] ERR_RESULT = 9'h1FF;

  typedef struct packed {
    op_e            op;
    logic [B_W-1:0] b;
    logic [A_W-1:0] a;
  } req_t;

  function automatic req_t unpack_req(input logic [REQ_W-1:0] raw);
    req_t r;
    r.op = op_e'(raw[OP_OFF +: OP_W]);
    r.b  = raw[B_OFF +: B_W];
    r.a  = raw[A_OFF +: A_W];
    return r;
  endfunction

  // Divide-by-zero never reaches the ALU; the arbiter answers it directly.
  function automatic logic is_div_by_zero(input op_e op, input logic [B_W-1:0] b);
    return (op == OP_DIV) && (b == '0);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, ALU and response buses around the ALU arbiter.
// Latency: n/a (wires only). Backpressure: req_ready accepts requests, rsp_ready drains responses.
// Modports: slave = arbiter view, master = environment (requesters, ALU, consumer) view.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import alu_pkg::*;

  // requester side
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*REQ_W-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  // ALU side
  logic                     alu_start;
  logic [OP_W-1:0]          alu_op;
  logic [A_W-1:0]           alu_a;
  logic [B_W-1:0]           alu_b;
  logic                     alu_done;
  logic [RES_W-1:0]         alu_result;
  // response side
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [RES_W-1:0]         rsp_result;
  logic                     rsp_err;
  logic                     rsp_ready;

  modport slave (
    input  req_valid, req_data, alu_done, alu_result, rsp_ready,
    output req_ready, alu_start, alu_op, alu_a, alu_b,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport master (
    output req_valid, req_data, alu_done, alu_result, rsp_ready,
    input  req_ready, alu_start, alu_op, alu_a, alu_b,
           rsp_valid, rsp_id, rsp_result, rsp_err
  );

endinterface

// File: rtl/alu_arbiter_rr.sv
// Round-robin picker: first requester at or after last_grant+1 (mod NUM_REQ).
// Latency: combinational. Backpressure: none; the caller decides when the grant is used.
// Ports: req_i request vector, last_grant_i previous winner, gnt_o one-hot grant, gnt_idx_o grant index.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  // Work on vectors padded to MAX_REQ so a 3-bit index always fits exactly.
  logic [MAX_REQ-1:0] req_pad;
  logic [MAX_REQ-1:0] gnt_pad;
  logic [ID_W-1:0]    cand;
  logic               found;
  int                 sum;

  always_comb begin
    req_pad              = '0;
    req_pad[NUM_REQ-1:0] = req_i;
    gnt_pad              = '0;
    gnt_idx_o            = '0;
    cand                 = '0;
    found                = 1'b0;
    sum                  = 0;
    // Scan NUM_REQ candidates starting one past the last winner, wrapping once.
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = int'(last_grant_i) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      cand = ID_W'(sum);
      if (!found && req_pad[cand]) begin
        found         = 1'b1;
        gnt_pad[cand] = 1'b1;
        gnt_idx_o     = cand;
      end
    end
    gnt_o = gnt_pad[NUM_REQ-1:0];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one multi-cycle ALU among NUM_REQ requesters, one request in flight at a time.
// Latency: grant N, alu_start N+1, rsp_valid N+3 at best (N+2 for divide-by-zero); TIMEOUT bounds the ALU wait.
// Backpressure: no grant outside IDLE; the response is held until rsp_ready.
// Ports: clk, reset (async, active-high), bus (alu_arbiter_if.slave: requester, ALU and response buses).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [ID_W-1:0]  id_q, id_d;
  op_e              op_q, op_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               alu_start_c;
  logic [REQ_W-1:0]   sel_raw;
  req_t               sel_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i        (bus.req_valid),
    .last_grant_i (last_q),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx)
  );

  // One-hot mux of the granted requester's slice.
  always_comb begin
    sel_raw = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) sel_raw = bus.req_data[i*REQ_W +: REQ_W];
    end
    sel_req = unpack_req(sel_raw);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);  // requester 0 wins first
      id_q    <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    err_d       = err_q;
    req_ready_c = '0;
    alu_start_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = gnt;
          id_d        = gnt_idx;
          op_d        = sel_req.op;
          a_d         = sel_req.a;
          b_d         = sel_req.b;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (is_div_by_zero(op_q, b_q)) begin
          res_d   = ERR_RESULT;
          err_d   = 1'b1;
          state_d = RESPOND;
        end else begin
          alu_start_c = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // A done arriving on the last allowed cycle still wins over the timeout.
        if (bus.alu_done) begin
          res_d   = bus.alu_result;
          err_d   = 1'b0;
          state_d = RESPOND;
        end else if (cnt_q >= CNT_LAST) begin
          res_d   = ERR_RESULT;
          err_d   = 1'b1;
          state_d = RESPOND;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESPOND: begin
        if (bus.rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The grant path is combinational from req_valid, so hold it off while reset is asserted.
  assign bus.req_ready  = reset ? '0 : req_ready_c;
  assign bus.alu_start  = alu_start_c;
  assign bus.alu_op     = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.rsp_valid  = (state_q == RESPOND);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_err    = err_q;

endmodule
